// File: rtl/pll_rst_ctrl.sv
// Purpose : PLL reset sequencer on the refclk domain. It pulses the PLL reset and waits
//           for lock. Lock must then stay stable before the downstream system reset is
//           released. Timed-out attempts are retried a bounded number of times before a
//           sticky failure is flagged.
// Latency : pll_lock is seen through a 2-flop synchronizer. Outputs are registered and
//           decoded from the next state, so they react 3 refclk edges after a pll_lock edge.
// Backpr. : none; this is a free-running control FSM with no handshake.
//
// Ports:
//   refclk     in   reference clock (same net as the PLL refclk)
//   reset      in   asynchronous active-high block reset
//   pll_lock   in   PLL lock indication, asynchronous to refclk
//   pll_rst    out  active-high PLL reset
//   sys_rst_n  out  active-low downstream reset, released only in RUN
//   locked_ok  out  high while in RUN
//   fail       out  sticky failure flag, cleared only by reset
//   retry_cnt  out  failed attempts in the current sequence
module pll_rst_ctrl #(
    parameter int RST_CYCLES    = 24,
    parameter int LOCK_TIMEOUT  = 24000,
    parameter int STABLE_CYCLES = 240,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       locked_ok,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Terminal counts, sized to the counter so every compare is width-matched.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             sync1_q, lock_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             locked_ok_q, locked_ok_d;
    logic             fail_q, fail_d;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock arriving on the timeout cycle wins; no retry is charged.
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 4'd1;
                    if (retry_d == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_ASSERT;
                    end
                end
            end
            ST_STABLE: begin
                // A lock drop restarts the lock window without charging a retry.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        // A good lock ends the sequence, so the retry history is dropped on RUN entry.
        if (state_d == ST_RUN) begin
            retry_d = 4'd0;
        end

        // The counter restarts on every state change and saturates otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // Outputs decoded from the next state, so they register on the same edge as the state.
        pll_rst_d   = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
        sys_rst_n_d = (state_d == ST_RUN);
        locked_ok_d = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_ok_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            locked_ok_q <= locked_ok_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign locked_ok = locked_ok_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Purpose : directed bench for pll_rst_ctrl with small timing parameters.
// Latency : checks are taken 1 time unit after each rising refclk edge.
// Backpr. : not applicable.
//
// Expected output vectors are packed as {pll_rst, sys_rst_n, locked_ok, fail, retry_cnt[3:0]}.
// Edge numbers in the comments count rising refclk edges after reset release.
module tb_pll_rst_ctrl;

    logic       refclk;
    logic       reset;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       locked_ok;
    logic       fail;
    logic [3:0] retry_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    pll_rst_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (3),
        .CNT_W        (16)
    ) dut (
        .refclk   (refclk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .locked_ok(locked_ok),
        .fail     (fail),
        .retry_cnt(retry_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {pll_rst, sys_rst_n, locked_ok, fail, retry_cnt};
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Release reset 1 time unit after a rising edge, so the next edge is edge 1.
    task automatic release_reset();
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b1;
        step(2);
        chk("reset_values", 8'b1000_0000);

        // Lock tied high: ASSERT for edges 1-4, STABLE from edge 5, RUN at edge 13.
        reset = 1'b0;
        step(3);  chk("s1_rst_hi_e3", 8'b1000_0000);
        step(1);  chk("s1_rst_lo_e4", 8'b0000_0000);
        step(8);  chk("s1_stable_e12", 8'b0000_0000);
        step(1);  chk("s1_run_e13", 8'b0110_0000);
        step(5);  chk("s1_run_hold", 8'b0110_0000);

        // Asynchronous reset while in RUN.
        reset    = 1'b1;
        pll_lock = 1'b0;
        #1;       chk("rst_mid_run_async", 8'b1000_0000);
        release_reset();

        // Lock held low: three 24-cycle rounds ending in FAIL at edge 72.
        step(23); chk("s2_wait1_e23", 8'b0000_0000);
        step(1);  chk("s2_retry1_e24", 8'b1000_0001);
        step(4);  chk("s2_wait2_e28", 8'b0000_0001);
        step(20); chk("s2_retry2_e48", 8'b1000_0010);
        step(4);  chk("s2_wait3_e52", 8'b0000_0010);
        step(19); chk("s2_wait3_e71", 8'b0000_0010);
        step(1);  chk("s2_fail_e72", 8'b1001_0011);
        pll_lock = 1'b1;
        step(50); chk("s2_fail_sticky", 8'b1001_0011);

        // Lock rises on the 2nd attempt.
        reset    = 1'b1;
        pll_lock = 1'b0;
        #1;       chk("rst_from_fail", 8'b1000_0000);
        release_reset();
        step(24); chk("s3_retry1_e24", 8'b1000_0001);
        step(4);  chk("s3_wait2_e28", 8'b0000_0001);
        pll_lock = 1'b1;
        step(3);  chk("s3_stable_e31", 8'b0000_0001);
        step(7);  chk("s3_stable_e38", 8'b0000_0001);
        step(1);  chk("s3_run_e39", 8'b0110_0000);

        // One-cycle lock glitch seen by the FSM at STABLE count 5 (edge 11).
        reset = 1'b1;
        #1;       chk("rst_mid_run2", 8'b1000_0000);
        release_reset();
        step(8);  chk("s4_stable_e8", 8'b0000_0000);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);  chk("s4_glitch_e11", 8'b0000_0000);
        step(2);  chk("s4_no_early_run_e13", 8'b0000_0000);
        step(6);  chk("s4_stable_e19", 8'b0000_0000);
        step(1);  chk("s4_run_e20", 8'b0110_0000);

        // Lock drop in RUN: sys_rst_n falls on the 3rd edge, then the sequence re-runs.
        step(2);
        pll_lock = 1'b0;
        step(2);  chk("s5_still_run_p2", 8'b0110_0000);
        step(1);  chk("s5_drop_p3", 8'b1000_0000);
        pll_lock = 1'b1;
        step(3);  chk("s5_assert_p6", 8'b1000_0000);
        step(1);  chk("s5_wait_p7", 8'b0000_0000);
        step(8);  chk("s5_stable_p15", 8'b0000_0000);
        step(1);  chk("s5_rerun_p16", 8'b0110_0000);

        // Asynchronous reset mid-WAIT_LOCK during the 2nd attempt, then a clean restart.
        reset    = 1'b1;
        pll_lock = 1'b0;
        #1;
        release_reset();
        step(30); chk("s6_wait2_e30", 8'b0000_0001);
        reset = 1'b1;
        #1;       chk("s6_rst_mid_wait", 8'b1000_0000);
        pll_lock = 1'b1;
        release_reset();
        step(3);  chk("s6_restart_e3", 8'b1000_0000);
        step(1);  chk("s6_restart_e4", 8'b0000_0000);
        step(8);  chk("s6_restart_e12", 8'b0000_0000);
        step(1);  chk("s6_restart_run_e13", 8'b0110_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_rst_ctrl.md
Name: pll_rst_ctrl

Overview:
Sequencer on the 24 MHz reference-clock side that drives the PLL's active-high reset input and watches its lock output. It pulses the PLL reset, waits for lock, qualifies lock stability, and only then releases the system reset that feeds logic on the PLL output clocks. If lock is not reached in time, it retries a bounded number of times, then flags a hard failure. Loss of lock during operation re-runs the sequence.

Parameters:
RST_CYCLES, 24, refclk cycles pll_rst is held high per attempt (1 us at 24 MHz); minimum 1.
LOCK_TIMEOUT, 24000, refclk cycles allowed in WAIT_LOCK before the attempt counts as failed (1 ms).
STABLE_CYCLES, 240, consecutive synchronized-lock-high cycles required before release (10 us).
MAX_RETRY, 3, failed attempts allowed before entering FAIL; range 1..15.
CNT_W, 16, width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
refclk  input  1  reference clock, same net as the PLL refclk.
reset  input  1  asynchronous, active-high block reset.
pll_lock  input  1  PLL lock indication, asynchronous to refclk.
pll_rst  output  1  active-high reset to the PLL.
sys_rst_n  output  1  active-low reset to downstream logic; deasserted only in RUN.
locked_ok  output  1  high while in RUN.
fail  output  1  sticky high in FAIL.
retry_cnt  output  4  number of failed attempts in the current sequence.

Behaviour:
- One clock, refclk. reset is asynchronous, active-high. All flops use posedge refclk and posedge reset.
- pll_lock passes through a 2-flop synchronizer (lock_s). Every decision uses lock_s, so response latency to pll_lock is 2 cycles plus the FSM register.
- Values during reset: state = ASSERT, counter = 0, retry_cnt = 0, pll_rst = 1, sys_rst_n = 0, locked_ok = 0, fail = 0, synchronizer = 0.
- States and transitions; the counter clears on every state change:
  - ASSERT: pll_rst = 1. After RST_CYCLES cycles (counter == RST_CYCLES-1), go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst = 0. If lock_s = 1, go to STABLE. Else if counter == LOCK_TIMEOUT-1, increment retry_cnt. If the new retry_cnt == MAX_RETRY, go to FAIL; otherwise go to ASSERT.
  - STABLE: If lock_s = 0, go to WAIT_LOCK; the timeout window restarts and retry_cnt is unchanged. If counter == STABLE_CYCLES-1 with lock_s = 1, go to RUN.
  - RUN: sys_rst_n = 1, locked_ok = 1, retry_cnt cleared to 0. If lock_s = 0, go to ASSERT immediately, with sys_rst_n = 0 from the next cycle.
  - FAIL: pll_rst = 1, sys_rst_n = 0, fail = 1. Exited only by reset.
- Simultaneous events: in WAIT_LOCK, lock_s = 1 on the timeout cycle takes priority and goes to STABLE with no retry counted.
- All outputs are registered. They are decoded from the next state so they change on the same edge as the state; no glitches.
- sys_rst_n release happens only via a STABLE to RUN transition. No path asserts sys_rst_n = 1 while pll_rst = 1.
- The counter saturates and never wraps. With legal parameters it cannot overflow.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3.
- Reset release with pll_lock tied high:
  - pll_rst is high for cycles 1-4, then low.
  - sys_rst_n rises 8 cycles after entering STABLE.
  - locked_ok = 1 and retry_cnt = 0.
- pll_lock held low:
  - Three ASSERT/WAIT_LOCK rounds occur (4 high + 20 low each).
  - retry_cnt steps 1, 2, 3.
  - fail = 1 and pll_rst = 1 stay sticky; sys_rst_n never rises.
- pll_lock rises on the 2nd attempt:
  - retry_cnt = 1 during that attempt.
  - After reaching RUN, retry_cnt = 0 and fail = 0.
- Lock glitch low for 1 cycle at STABLE count 5: the block returns to WAIT_LOCK, then needs a full 8-cycle stable window; sys_rst_n stays 0 throughout.
- pll_lock drops in RUN:
  - sys_rst_n falls 3 cycles after the pll_lock edge (2 synchronizer cycles plus the FSM register).
  - pll_rst pulses for 4 cycles and the sequence re-runs to RUN.
- reset asserted mid-WAIT_LOCK and mid-RUN: outputs immediately (asynchronously) take their reset values, and the sequence restarts from ASSERT.
